// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA timing generator and DAC output stage.
// Sync/blank are delayed to line up with the drawers' registered colour.
module vga_timing_controller #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  RGBin,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic        hSyncN,
   output logic        vSyncN,
   output logic        blankN,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue
);

   localparam logic [10:0] H_LAST =
      11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [10:0] V_LAST =
      11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic        visible;
   logic        hs;
   logic        vs;
   logic [PIPE_DELAY-1:0] vis_q;
   logic [PIPE_DELAY-1:0] hs_q;
   logic [PIPE_DELAY-1:0] vs_q;
   logic [2:0]  r3;
   logic [2:0]  g3;
   logic [1:0]  b2;

   assign {r3, g3, b2} = RGBin;

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   always_comb begin
      visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   end

   // Clearing the delay line on reset keeps stale sync out of the outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         vis_q <= '0;
         hs_q  <= '0;
         vs_q  <= '0;
      end else begin
         vis_q[0] <= visible;
         hs_q[0]  <= hs;
         vs_q[0]  <= vs;
         for (int i = 1; i < PIPE_DELAY; i++) begin
            vis_q[i] <= vis_q[i-1];
            hs_q[i]  <= hs_q[i-1];
            vs_q[i]  <= vs_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hSyncN <= 1'b1;
         vSyncN <= 1'b1;
         blankN <= 1'b0;
         red    <= '0;
         green  <= '0;
         blue   <= '0;
      end else begin
         hSyncN <= ~hs_q[PIPE_DELAY-1];
         vSyncN <= ~vs_q[PIPE_DELAY-1];
         blankN <= vis_q[PIPE_DELAY-1];
         if (vis_q[PIPE_DELAY-1]) begin
            red   <= {r3, r3, r3[2:1]};
            green <= {g3, g3, g3[2:1]};
            blue  <= {b2, b2, b2, b2};
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

   assign pixelX       = h_cnt;
   assign pixelY       = v_cnt;
   assign startOfFrame = ~reset && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_controller.sv
// Self-checking bench for vga_timing_controller (scoreboard + directed).
// Vertical timing is shortened so whole frames fit a short run.
module tb_vga_timing_controller;

   localparam int P   = 1;
   localparam int HT  = 800;
   localparam int VV  = 20;
   localparam int VF  = 3;
   localparam int VS  = 2;
   localparam int VB  = 2;
   localparam int VT  = VV + VF + VS + VB;

   logic        clk;
   logic        reset;
   logic [7:0]  RGBin;
   logic [10:0] pixelX, pixelY, pixelX3, pixelY3;
   logic        startOfFrame, hSyncN, vSyncN, blankN;
   logic        sof3, hSyncN3, vSyncN3, blankN3;
   logic [7:0]  red, green, blue, red3, green3, blue3;

   vga_timing_controller #(
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY(P)
   ) u_dut (
      .clk(clk), .reset(reset), .RGBin(RGBin),
      .pixelX(pixelX), .pixelY(pixelY),
      .startOfFrame(startOfFrame),
      .hSyncN(hSyncN), .vSyncN(vSyncN), .blankN(blankN),
      .red(red), .green(green), .blue(blue)
   );

   vga_timing_controller #(
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY(3)
   ) u_dut3 (
      .clk(clk), .reset(reset), .RGBin(RGBin),
      .pixelX(pixelX3), .pixelY(pixelY3),
      .startOfFrame(sof3),
      .hSyncN(hSyncN3), .vSyncN(vSyncN3), .blankN(blankN3),
      .red(red3), .green(green3), .blue(blue3)
   );

   typedef struct {
      int          due;
      logic [26:0] out;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   ex    = 0;
   int   ey    = 0;
   bit   sb_en = 0;
   bit   cmode = 1;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [26:0] expect_out(int x, int y, logic [7:0] c);
      logic vis, hs, vs;
      vis = (x < 640) && (y < VV);
      hs  = (x >= 656) && (x < 752);
      vs  = (y >= VV + VF) && (y < VV + VF + VS);
      if (vis)
         return {~hs, ~vs, 1'b1, c[7:5], c[7:5], c[7:6],
                 c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
      return {~hs, ~vs, 1'b0, 24'h0};
   endfunction

   // Scoreboard: push per coordinate, pop when the output slot arrives
   initial begin
      logic [7:0] rgb_now;
      logic [7:0] rgb_prev;
      exp_t       e;
      rgb_prev = 8'h00;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (!sb_en) q.delete();
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("sb_out", {hSyncN, vSyncN, blankN, red, green, blue},
                64'(e.out));
         end
         rgb_now = cmode ? pixelX[7:0] : 8'hFF;
         if (sb_en) begin
            chk("sb_coord", {pixelX, pixelY, startOfFrame},
                {11'(ex), 11'(ey), 1'(ex == 0 && ey == 0)});
            e.due = cyc + P + 1;
            e.out = expect_out(ex, ey, rgb_now);
            q.push_back(e);
            if (ex == HT - 1) begin
               ex = 0;
               ey = (ey == VT - 1) ? 0 : ey + 1;
            end else begin
               ex++;
            end
         end
         RGBin    = rgb_prev;
         rgb_prev = rgb_now;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_xy(input int x, input int y, input string tag);
      int n = 0;
      while (!(pixelX == 11'(x) && pixelY == 11'(y)) && n < 30000) begin
         step();
         n++;
      end
      chk(tag, {pixelX, pixelY}, {11'(x), 11'(y)});
   endtask

   initial begin
      int n, w, p, n3, nv, nf, nr, nsof, bad;
      reset = 1;
      RGBin = 8'h00;
      repeat (3) step();
      chk("rst_coord", {pixelX, pixelY, startOfFrame}, 0);
      chk("rst_out", {hSyncN, vSyncN, blankN, red, green, blue},
          {3'b110, 24'h0});
      chk("rst_out3", {hSyncN3, vSyncN3, blankN3}, 3'b110);

      @(negedge clk);
      reset = 0;
      ex = 0;
      ey = 0;
      sb_en = 1;
      #1;
      chk("rel_sof", {pixelX, pixelY, startOfFrame}, 23'h1);

      n = 0;
      while (!blankN3 && n < 20) begin
         step();
         n++;
      end
      chk("p3_blank_rise", n, 4);

      wait_xy(88, 0, "wait_x88");
      step();
      step();
      chk("col_58", {blankN, red, green, blue}, {1'b1, 24'h49DB00});
      wait_xy(255, 0, "wait_x255");
      step();
      step();
      chk("col_ff", {blankN, red, green, blue}, {1'b1, 24'hFFFFFF});
      wait_xy(640, 0, "wait_x640");
      step();
      step();
      chk("col_x640", {blankN, red, green, blue}, 25'h0);

      wait_xy(656, 0, "wait_x656");
      n = 0;
      while (hSyncN && n < 20) begin
         step();
         n++;
      end
      chk("hs_fall_lat", n, 2);
      w = 0;
      while (!hSyncN && w < 2000) begin
         step();
         w++;
      end
      chk("hs_width", w, 96);
      p = w;
      while (hSyncN && p < 2000) begin
         step();
         p++;
      end
      chk("line_period", p, 800);

      wait_xy(656, 2, "wait_x656_p3");
      n3 = 0;
      while (hSyncN3 && n3 < 20) begin
         step();
         n3++;
      end
      chk("p3_hs_fall_lat", n3, 4);

      n = 0;
      while (!startOfFrame && n < 25000) begin
         step();
         n++;
      end
      chk("wait_sof", startOfFrame, 1);
      cmode = 0;
      n = 0;
      nv = -1;
      nf = -1;
      nr = -1;
      nsof = -1;
      bad = 0;
      while (nsof < 0 && n < 25000) begin
         step();
         n++;
         if (startOfFrame) nsof = n;
         if (pixelX == 0 && pixelY == 11'(VV + VF) && nv < 0) nv = n;
         if (!vSyncN && nf < 0) nf = n;
         if (vSyncN && nf >= 0 && nr < 0) nr = n;
         if (pixelX == 641 && pixelY == 0)
            chk("gate_x639", red, 8'hFF);
         if (pixelX == 642 && pixelY == 0)
            chk("gate_x640", {blankN, red, green, blue}, 25'h0);
         if (pixelY >= 11'(VV) && (blankN || red != 0 || green != 0 ||
             blue != 0)) bad++;
      end
      chk("frame_period", nsof, 21600);
      chk("vs_fall_lat", nf - nv, 2);
      chk("vs_width", nr - nf, 1600);
      chk("blank_rows", bad, 0);

      wait_xy(299, 10, "wait_mid");
      @(negedge clk);
      sb_en = 0;
      reset = 1;
      #1;
      @(negedge clk);
      reset = 0;
      ex = 0;
      ey = 0;
      sb_en = 1;
      #1;
      chk("mid_rst", {hSyncN, vSyncN, blankN, pixelX, pixelY, startOfFrame},
          {3'b110, 22'h0, 1'b1});
      chk("mid_rst3", {hSyncN3, vSyncN3, blankN3}, 3'b110);
      n = 0;
      while (hSyncN && n < 2000) begin
         step();
         n++;
      end
      chk("mid_hs_first", n, 658);
      p = 0;
      while (!hSyncN && p < 2000) begin
         step();
         p++;
      end
      while (hSyncN && p < 2000) begin
         step();
         p++;
      end
      chk("mid_line_period", p, 800);

      repeat (4) step();
      sb_en = 0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Pixel-clock VGA timing generator and output stage for 640x480@60.
- Produces the pixelX/pixelY coordinates that every drawing block consumes.
- Accepts the merged 8-bit RRRGGGBB pixel colour those blocks return.
- Drives the DAC-facing sync, blank and 8-bit-per-channel colour outputs, with sync/blank delayed to match the drawers' registered RGB latency.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
PIPE_DELAY, 1, clocks from pixelX/pixelY to valid RGBin (range 1..4)

Ports:
clk  in  1  pixel clock, 25.175 MHz nominal; single clock domain
reset  in  1  synchronous, active-high reset
RGBin  in  8  pixel colour from drawers, {R[2:0],G[2:0],B[1:0]}
pixelX  out  11  current horizontal count, 0..H_TOTAL-1
pixelY  out  11  current vertical count, 0..V_TOTAL-1
startOfFrame  out  1  one-clock pulse while pixelX==0 && pixelY==0
hSyncN  out  1  horizontal sync, active low
vSyncN  out  1  vertical sync, active low
blankN  out  1  high during visible pixels, aligned with colour outputs
red  out  8  expanded red
green  out  8  expanded green
blue  out  8  expanded blue

Behaviour:
- Totals:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
- Counters:
  - hCnt increments every clock.
  - At H_TOTAL-1, hCnt wraps to 0 and vCnt increments.
  - When vCnt is at V_TOTAL-1 and hCnt wraps, vCnt wraps to 0.
- Coordinate outputs:
  - pixelX = hCnt and pixelY = vCnt, taken directly from registers with no extra delay.
  - Coordinates run through blanking; drawers see values >= 640/480 there.
- Raw timing decodes, computed from the counters:
  - visible = (hCnt < H_VISIBLE) && (vCnt < V_VISIBLE).
  - hs = hCnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752).
  - vs = vCnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492).
  - vs is evaluated per clock, so it changes at the hCnt==0 boundary of the line.
- Alignment:
  - visible, hs and vs pass through a PIPE_DELAY-stage shift register.
  - Delayed values plus RGBin are captured into the output registers.
  - Result: hSyncN, vSyncN, blankN, red, green and blue for coordinate (x,y) appear exactly PIPE_DELAY+1 clocks after pixelX==x, pixelY==y.
- Colour expansion, applied only when delayed visible=1:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - When delayed visible=0: red, green and blue = 0 and blankN = 0, regardless of RGBin.
- startOfFrame:
  - Decoded from the counter registers; high for exactly one clock per frame.
  - Forced 0 while reset=1.
- Reset values, on the clock edge with reset=1:
  - Counters = 0.
  - Shift register cleared: visible=0, hs=0, vs=0.
  - hSyncN = 1, vSyncN = 1, blankN = 0, red = green = blue = 0.
- Reset release: the first clock with reset=0 has pixelX=0, pixelY=0 and startOfFrame=1.
- Reset mid-frame:
  - Same as above; counters restart at 0,0 on the next edge.
  - No partial sync pulse is emitted from stale pipeline contents.
- Sync during reset: no sync pulse is generated while reset is held.
- Widths: 11-bit counters cover up to 2047; comparisons are unsigned.

Test Plan:
- Line period: release reset, count clocks between falling edges of hSyncN -> exactly 800. The first falling edge occurs PIPE_DELAY+1 = 2 clocks after pixelX==656. Low width = 96 clocks.
- Frame period: run 2 frames -> startOfFrame pulses exactly 420000 clocks apart. vSyncN is low for 1600 clocks, starting 2 clocks after pixelX==0, pixelY==490.
- Colour expansion, with RGBin driven from pixelX at 1-cycle latency:
  - RGBin = 8'b010_110_00 -> red = 8'h49, green = 8'hDB, blue = 8'h00 with blankN=1.
  - RGBin = 8'hFF -> red = green = blue = 8'hFF.
- Blank gating: hold RGBin = 8'hFF constantly.
  - At the output slot for x=639, red = 8'hFF.
  - At the slot for x=640, and for all of y=480..524: red = green = blue = 0 and blankN = 0.
- Reset mid-frame: assert reset for 1 clock at pixelX=300, pixelY=200.
  - Next clock: hSyncN = vSyncN = 1, blankN = 0.
  - First post-reset clock: pixelX = 0, pixelY = 0, startOfFrame = 1.
  - Following line period is exactly 800 clocks.
- PIPE_DELAY=3 build: hSyncN first falls 4 clocks after pixelX==656, and blankN first rises 4 clocks after pixelX==0, pixelY==0.
